// File: rtl/servo_ctrl_pkg.sv
// Shared types and helpers for the servo command sequencer.
package servo_ctrl_pkg;
  localparam int ANGLE_W = 12;

  typedef enum logic [1:0] {
    ARM    = 2'd0,
    RUN    = 2'd1,
    HOLD   = 2'd2,
    HOMING = 2'd3
  } seq_state_t;

  function automatic logic [ANGLE_W-1:0] clamp_angle(
    input logic [ANGLE_W-1:0] value,
    input logic [ANGLE_W-1:0] lo,
    input logic [ANGLE_W-1:0] hi
  );
    if (value < lo) return lo;
    else if (value > hi) return hi;
    else return value;
  endfunction
endpackage

// File: rtl/servo_slew_step.sv
// One-axis slew limiter: moves angle toward target by at most MAX_STEP, never overshooting.
module servo_slew_step
  import servo_ctrl_pkg::*;
#(
  parameter int MAX_STEP = 64
) (
  input  logic [ANGLE_W-1:0] angle,
  input  logic [ANGLE_W-1:0] target,
  output logic [ANGLE_W-1:0] next_angle
);
  localparam logic [ANGLE_W:0]   STEP_WIDE = (ANGLE_W+1)'(MAX_STEP);
  localparam logic [ANGLE_W-1:0] STEP      = ANGLE_W'(MAX_STEP);

  logic signed [ANGLE_W:0] diff;
  logic        [ANGLE_W:0] mag;

  assign diff = $signed({1'b0, target}) - $signed({1'b0, angle});

  always_comb begin
    mag = diff[ANGLE_W] ? unsigned'(-diff) : unsigned'(diff);
    if (mag <= STEP_WIDE) next_angle = target;
    else if (diff[ANGLE_W]) next_angle = angle - STEP;
    else next_angle = angle + STEP;
  end
endmodule

// File: rtl/servo_cmd_sequencer.sv
// Clamps target angle pairs, slew-limits both servo axes once per PWM frame and
// sequences arm / run / hold / homing.
module servo_cmd_sequencer
  import servo_ctrl_pkg::*;
#(
  parameter int UPDATE_DIV = 1064960,
  parameter int MAX_STEP   = 64,
  parameter int HOME_ANGLE = 2048,
  parameter int ANGLE_MIN  = 0,
  parameter int ANGLE_MAX  = 4095,
  parameter int ARM_TICKS  = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [ANGLE_W-1:0] cmd_x,
  input  logic [ANGLE_W-1:0] cmd_y,
  input  logic               freeze,
  input  logic               home_req,
  output logic [ANGLE_W-1:0] angle_x,
  output logic [ANGLE_W-1:0] angle_y,
  output logic               pwm_enable,
  output logic               update_tick,
  output logic               at_target,
  output logic [1:0]         state
);
  localparam int CNT_W = (UPDATE_DIV > 1) ? $clog2(UPDATE_DIV) : 1;
  localparam int ARM_W = $clog2(ARM_TICKS + 1);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(UPDATE_DIV - 1);
  localparam logic [ARM_W-1:0]   ARM_LAST = ARM_W'(ARM_TICKS - 1);
  localparam logic [ANGLE_W-1:0] HOME     = ANGLE_W'(HOME_ANGLE);
  localparam logic [ANGLE_W-1:0] LO       = ANGLE_W'(ANGLE_MIN);
  localparam logic [ANGLE_W-1:0] HI       = ANGLE_W'(ANGLE_MAX);

  seq_state_t         cur_state, nxt_state;
  logic [CNT_W-1:0]   frame_cnt;
  logic [ARM_W-1:0]   arm_cnt;
  logic [ANGLE_W-1:0] target_x, target_y;
  logic [ANGLE_W-1:0] slew_x, slew_y;
  logic [ANGLE_W-1:0] angle_x_nxt, angle_y_nxt, target_x_nxt, target_y_nxt;
  logic               tick, slewing, xfer, homing_entry;

  assign tick = (frame_cnt == CNT_LAST);

  servo_slew_step #(.MAX_STEP(MAX_STEP)) u_slew_x (
    .angle(angle_x), .target(target_x), .next_angle(slew_x)
  );
  servo_slew_step #(.MAX_STEP(MAX_STEP)) u_slew_y (
    .angle(angle_y), .target(target_y), .next_angle(slew_y)
  );

  // Angles move only on a tick in RUN/HOMING, always toward the pre-transfer target.
  always_comb begin
    slewing     = tick && (cur_state == RUN || cur_state == HOMING);
    angle_x_nxt = slewing ? slew_x : angle_x;
    angle_y_nxt = slewing ? slew_y : angle_y;
  end

  always_comb begin
    nxt_state = cur_state;
    case (cur_state)
      ARM:     if (tick && arm_cnt == ARM_LAST) nxt_state = RUN;
      RUN:     if (home_req) nxt_state = HOMING;
               else if (freeze) nxt_state = HOLD;
      HOLD:    if (home_req) nxt_state = HOMING;
               else if (!freeze) nxt_state = RUN;
      HOMING:  if (tick && angle_x_nxt == HOME && angle_y_nxt == HOME) nxt_state = RUN;
      default: nxt_state = ARM;
    endcase
  end

  // Handshake: a pair transfers on any clock edge where cmd_valid && cmd_ready;
  // cmd_ready depends only on state, never on cmd_valid. No queue: last transfer wins.
  always_comb begin
    cmd_ready = (cur_state == RUN) || (cur_state == HOLD);
    state     = cur_state;
  end

  always_comb begin
    xfer         = cmd_valid && cmd_ready;
    homing_entry = (nxt_state == HOMING) && (cur_state != HOMING);
    target_x_nxt = target_x;
    target_y_nxt = target_y;
    if (homing_entry) begin
      target_x_nxt = HOME;
      target_y_nxt = HOME;
    end else if (xfer) begin
      target_x_nxt = clamp_angle(cmd_x, LO, HI);
      target_y_nxt = clamp_angle(cmd_y, LO, HI);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cur_state   <= ARM;
      frame_cnt   <= '0;
      arm_cnt     <= '0;
      angle_x     <= HOME;
      angle_y     <= HOME;
      target_x    <= HOME;
      target_y    <= HOME;
      pwm_enable  <= 1'b0;
      update_tick <= 1'b0;
      at_target   <= 1'b1;
    end else begin
      cur_state   <= nxt_state;
      frame_cnt   <= tick ? '0 : frame_cnt + 1'b1;
      if (cur_state == ARM && tick) arm_cnt <= arm_cnt + 1'b1;
      angle_x     <= angle_x_nxt;
      angle_y     <= angle_y_nxt;
      target_x    <= target_x_nxt;
      target_y    <= target_y_nxt;
      pwm_enable  <= pwm_enable || (cur_state == ARM && nxt_state == RUN);
      update_tick <= tick;
      at_target   <= (angle_x_nxt == target_x_nxt) && (angle_y_nxt == target_y_nxt);
    end
  end
endmodule

// File: tb/tb_servo_cmd_sequencer.sv
// Bench for servo_cmd_sequencer: directed scenarios plus random traffic against a reference model.
module tb_servo_cmd_sequencer;
  localparam int DIV  = 10;
  localparam int ARMT = 2;
  localparam int STEP = 64;
  localparam int HOME = 2048;
  localparam int LO   = 200;
  localparam int HI   = 3900;
  localparam int W    = 25;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready;
  logic [11:0] cmd_x = '0, cmd_y = '0;
  logic        freeze = 1'b0, home_req = 1'b0;
  logic [11:0] angle_x, angle_y;
  logic        pwm_enable, update_tick, at_target;
  logic [1:0]  state;

  int n_cmp = 0;
  int n_bad = 0;
  bit mon_en = 1'b0;

  servo_cmd_sequencer #(
    .UPDATE_DIV(DIV), .MAX_STEP(STEP), .HOME_ANGLE(HOME),
    .ANGLE_MIN(LO), .ANGLE_MAX(HI), .ARM_TICKS(ARMT)
  ) dut (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .freeze(freeze), .home_req(home_req),
    .angle_x(angle_x), .angle_y(angle_y), .pwm_enable(pwm_enable),
    .update_tick(update_tick), .at_target(at_target), .state(state)
  );

  // ---------------- clock / timeout ----------------
  always #5 clock = ~clock;

  initial begin
    #600000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (0=ARM 1=RUN 2=HOLD 3=HOMING) ----------------
  int m_ax = HOME, m_ay = HOME, m_tx = HOME, m_ty = HOME;
  int m_mode = 0, m_cnt = 0, m_arm = 0;
  bit m_pen = 0, m_ut = 0, m_at = 1;
  logic [W-1:0] exp_q[$];

  function automatic int move_toward(input int a, input int t);
    if (t > a) return a + ((t - a) > STEP ? STEP : t - a);
    return a - ((a - t) > STEP ? STEP : a - t);
  endfunction

  function automatic int clampi(input int v);
    return v < LO ? LO : (v > HI ? HI : v);
  endfunction

  always @(posedge clock) begin : model
    bit is_tick, acc;
    int prev;
    if (reset) begin
      m_ax = HOME; m_ay = HOME; m_tx = HOME; m_ty = HOME;
      m_mode = 0; m_cnt = 0; m_arm = 0; m_pen = 0; m_ut = 0; m_at = 1;
      exp_q.delete();
    end else begin
      is_tick = (m_cnt == DIV - 1);
      m_cnt = is_tick ? 0 : m_cnt + 1;
      acc = cmd_valid && (m_mode == 1 || m_mode == 2);
      if (is_tick && (m_mode == 1 || m_mode == 3)) begin
        m_ax = move_toward(m_ax, m_tx);
        m_ay = move_toward(m_ay, m_ty);
      end
      prev = m_mode;
      case (m_mode)
        0: if (is_tick) begin
             m_arm++;
             if (m_arm == ARMT) begin m_mode = 1; m_pen = 1; end
           end
        1: if (home_req) m_mode = 3; else if (freeze) m_mode = 2;
        2: if (home_req) m_mode = 3; else if (!freeze) m_mode = 1;
        default: if (is_tick && m_ax == HOME && m_ay == HOME) m_mode = 1;
      endcase
      if (m_mode == 3 && prev != 3) begin
        m_tx = HOME; m_ty = HOME;
      end else if (acc) begin
        m_tx = clampi(int'(cmd_x)); m_ty = clampi(int'(cmd_y));
      end
      m_at = (m_ax == m_tx) && (m_ay == m_ty);
      m_ut = is_tick;
      if (is_tick) exp_q.push_back({12'(m_ax), 12'(m_ay), m_at});
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clock) begin : monitor
    logic [W-1:0] e;
    if (mon_en) begin
      chk("state", int'(state), m_mode);
      chk("cmd_ready", int'(cmd_ready), int'(m_mode == 1 || m_mode == 2));
      chk("pwm_enable", int'(pwm_enable), int'(m_pen));
      chk("update_tick", int'(update_tick), int'(m_ut));
      if (update_tick) begin
        if (exp_q.size() == 0) chk("tick_without_expect", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("tick_angles_at", int'({angle_x, angle_y, at_target}), int'(e));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_tick();
    int k = 0;
    do begin
      @(negedge clock);
      k++;
    end while (!update_tick && k < 4 * DIV);
    chk("tick_wait", int'(update_tick), 1);
  endtask

  task automatic send(input int x, input int y);
    cmd_valid = 1'b1; cmd_x = 12'(x); cmd_y = 12'(y);
    @(negedge clock);
    cmd_valid = 1'b0;
  endtask

  task automatic settle();
    for (int i = 0; i < 80 && !at_target; i++) wait_tick();
    chk("settle", int'(at_target), 1);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_angle_x"}, int'(angle_x), HOME);
    chk({tag, "_angle_y"}, int'(angle_y), HOME);
    chk({tag, "_pwm_enable"}, int'(pwm_enable), 0);
    chk({tag, "_cmd_ready"}, int'(cmd_ready), 0);
    chk({tag, "_state"}, int'(state), 0);
    chk({tag, "_at_target"}, int'(at_target), 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    repeat (2) @(negedge clock);
    mon_en = 1'b1;
    check_reset_values("reset");
    reset = 1'b0;

    // arm sequence
    wait_tick();
    chk("arm_still_arm", int'(state), 0);
    wait_tick();
    chk("arm_run_state", int'(state), 1);
    chk("arm_pwm_on", int'(pwm_enable), 1);
    chk("arm_ready", int'(cmd_ready), 1);

    // ramp both axes
    send(2200, 1900);
    wait_tick(); chk("ramp1_x", int'(angle_x), 2112); chk("ramp1_y", int'(angle_y), 1984);
    wait_tick(); chk("ramp2_x", int'(angle_x), 2176); chk("ramp2_y", int'(angle_y), 1920);
    chk("ramp2_at", int'(at_target), 0);
    wait_tick(); chk("ramp3_x", int'(angle_x), 2200); chk("ramp3_y", int'(angle_y), 1900);
    chk("ramp3_at", int'(at_target), 1);

    // lower clamp
    send(300, 1900); settle();
    send(100, 1900);
    wait_tick(); chk("clamp_lo1", int'(angle_x), 236);
    wait_tick(); chk("clamp_lo2", int'(angle_x), 200);
    wait_tick(); chk("clamp_lo3", int'(angle_x), 200);

    // freeze mid-ramp, transfer while held
    send(1000, 1900);
    wait_tick(); wait_tick(); chk("pre_freeze_x", int'(angle_x), 328);
    freeze = 1'b1;
    @(negedge clock); chk("hold_state", int'(state), 2);
    for (int i = 0; i < 3; i++) begin
      wait_tick(); chk("hold_x", int'(angle_x), 328); chk("hold_y", int'(angle_y), 1900);
    end
    chk("hold_ready", int'(cmd_ready), 1);
    send(600, 2000);
    freeze = 1'b0;
    @(negedge clock); chk("resume_state", int'(state), 1);
    wait_tick(); chk("resume_x", int'(angle_x), 392); chk("resume_y", int'(angle_y), 1964);
    settle();

    // upper clamp then homing
    send(4000, 100); settle();
    chk("clamp_hi_x", int'(angle_x), HI); chk("clamp_lo_y", int'(angle_y), LO);
    home_req = 1'b1;
    @(negedge clock); home_req = 1'b0;
    chk("homing_state", int'(state), 3); chk("homing_ready", int'(cmd_ready), 0);
    cmd_valid = 1'b1; cmd_x = 12'd0; cmd_y = 12'd0;
    wait_tick(); chk("homing1_x", int'(angle_x), 3836); chk("homing1_y", int'(angle_y), 264);
    n = 1;
    while (state != 2'd1 && n < 40) begin wait_tick(); n++; end
    cmd_valid = 1'b0;
    chk("homing_ticks", n, 29);
    chk("homed_x", int'(angle_x), HOME); chk("homed_y", int'(angle_y), HOME);

    // transfer coincident with the tick edge
    send(2400, 2048);
    wait_tick(); chk("edge_pre_x", int'(angle_x), 2112);
    repeat (9) @(negedge clock);
    send(1000, 2048);
    chk("edge_tick", int'(update_tick), 1);
    chk("edge_old_target_x", int'(angle_x), 2176);
    wait_tick(); chk("edge_new_target_x", int'(angle_x), 2112);

    // reset during homing
    send(600, 2048); settle();
    home_req = 1'b1;
    @(negedge clock); home_req = 1'b0;
    wait_tick(); chk("mid_homing_x", int'(angle_x), 664); chk("mid_homing_state", int'(state), 3);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check_reset_values("mid_reset");
    chk("mid_reset_tick", int'(update_tick), 0);
    wait_tick(); wait_tick();
    chk("rearm_state", int'(state), 1);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      @(negedge clock);
      cmd_valid = ($urandom_range(0, 3) == 0);
      cmd_x     = 12'($urandom_range(0, 4095));
      cmd_y     = 12'($urandom_range(0, 4095));
      if ($urandom_range(0, 199) == 0) freeze = ~freeze;
      home_req  = ($urandom_range(0, 299) == 0);
      reset     = ($urandom_range(0, 999) == 0);
    end
    @(negedge clock);
    cmd_valid = 1'b0; freeze = 1'b0; home_req = 1'b0; reset = 1'b0;
    repeat (3 * DIV) @(negedge clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
